rf_write_arbiter: RTL

//  Shares the single register-file write port (Reg_Write / one-hot CP / data_in) between NUM_REQ writeback sources.

---
 rtl/rf_write_arbiter_if.sv | 29 ++
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: requester handshakes on one side,
// the single shared write port (strobe, one-hot select, data) on the other.
interface rf_write_arbiter_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REQ     = 3
);
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [5*NUM_REQ-1:0]           req_addr_i;
    logic [WORD_LENGTH*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic                           clear_start_i;
    logic                           Reg_Write_o;
    logic [31:0]                    CP_o;
    logic [WORD_LENGTH-1:0]         data_o;
    logic [2:0]                     grant_id_o;
    logic                           clear_busy_o;

    // Writeback stages (and the clear controller) drive requests.
    modport master (
        output req_valid_i, req_addr_i, req_data_i, clear_start_i,
        input  req_ready_o, Reg_Write_o, CP_o, data_o, grant_id_o, clear_busy_o
    );

    // The arbiter accepts requests and drives the register-file port.
    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, clear_start_i,
        output req_ready_o, Reg_Write_o, CP_o, data_o, grant_id_o, clear_busy_o
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// writeback sources, plus a 32-cycle hardware zero-fill sweep.
// Port outputs are registered: an accept on edge E is written at edge E+1.
module rf_write_arbiter #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REQ     = 3,
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             rr_q, rr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   reg_write_q, reg_write_d;
    logic [31:0]            cp_q, cp_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [2:0]             grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;

    // Requester fields padded to 8 entries so a 3-bit index always fits.
    logic [7:0]             valid_pad;
    logic [4:0]             addr_arr [8];
    logic [WORD_LENGTH-1:0] data_arr [8];

    logic                   accept;
    logic [2:0]             gnt;
    logic [7:0]             ready_pad;
    logic [4:0]             gnt_addr;
    logic [WORD_LENGTH-1:0] gnt_data;

    assign valid_pad = 8'(bus.req_valid_i);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_real
                assign addr_arr[gi] = bus.req_addr_i[5*gi +: 5];
                assign data_arr[gi] = bus.req_data_i[WORD_LENGTH*gi +: WORD_LENGTH];
            end else begin : g_pad
                assign addr_arr[gi] = '0;
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    // Round-robin scan from rr pointer; a clear request or a running sweep blocks all grants.
    always_comb begin
        logic [3:0] sum;
        accept = 1'b0;
        gnt    = 3'd0;
        sum    = 4'd0;
        if (state_q == IDLE && !bus.clear_start_i && !reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sum = {1'b0, rr_q} + 4'(i);
                if (sum >= 4'(NUM_REQ)) begin
                    sum = sum - 4'(NUM_REQ);
                end
                if (!accept && valid_pad[sum[2:0]]) begin
                    accept = 1'b1;
                    gnt    = sum[2:0];
                end
            end
        end
    end

    assign ready_pad       = accept ? (8'd1 << gnt) : 8'd0;
    assign bus.req_ready_o = ready_pad[NUM_REQ-1:0];
    assign gnt_addr        = addr_arr[gnt];
    assign gnt_data        = data_arr[gnt];

    // Next-state for FSM, rotation pointer, sweep counter and port registers.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        reg_write_d = 1'b0;
        cp_d        = 32'd0;
        data_d      = data_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_start_i) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd0;
                end else if (accept) begin
                    rr_d        = (gnt == 3'(NUM_REQ - 1)) ? 3'd0 : gnt + 3'd1;
                    // Writes to reg 0 are consumed but never reach the file when it is read-only.
                    reg_write_d = !(ZERO_REG_RO && gnt_addr == 5'd0);
                    cp_d        = reg_write_d ? (32'd1 << gnt_addr) : 32'd0;
                    data_d      = gnt_data;
                    grant_id_d  = gnt;
                end
            end
            CLEAR: begin
                // Sweep writes every register, including reg 0, with zero.
                reg_write_d = 1'b1;
                cp_d        = 32'd1 << cnt_q;
                data_d      = '0;
                grant_id_d  = 3'd0;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // State and registered outputs; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 3'd0;
            cnt_q       <= 5'd0;
            reg_write_q <= 1'b0;
            cp_q        <= 32'd0;
            data_q      <= '0;
            grant_id_q  <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            cp_q        <= cp_d;
            data_q      <= data_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.Reg_Write_o  = reg_write_q;
    assign bus.CP_o         = cp_q;
    assign bus.data_o       = data_q;
    assign bus.grant_id_o   = grant_id_q;
    assign bus.clear_busy_o = busy_q;
endmodule
